// File: rtl/pll_lock_supervisor_if.sv
// Lock supervisor signal bundle: the PLL-facing lock input plus the reset, status and
// event-counter outputs.
interface pll_lock_supervisor_if #(
  parameter int unsigned CNT_W = 8
);
  logic             i_locked;
  logic             o_pll_rst;
  logic             o_rst;
  logic             o_ready;
  logic [CNT_W-1:0] o_loss_count;
  logic [CNT_W-1:0] o_timeout_count;

  // Supervisor side drives the resets and counters.
  modport master (
    input  i_locked,
    output o_pll_rst, o_rst, o_ready, o_loss_count, o_timeout_count
  );

  // PLL/board side supplies lock and observes the supervisor.
  modport slave (
    output i_locked,
    input  o_pll_rst, o_rst, o_ready, o_loss_count, o_timeout_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, filters the synchronized lock signal and
// releases the core reset only after a stable lock plus a hold interval. Lock loss and
// lock timeout both re-reset the PLL and bump saturating event counters.
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 32,
  parameter int unsigned LOCK_FILTER    = 1024,
  parameter int unsigned RST_HOLD       = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned CNT_W          = 8
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  pll_lock_supervisor_if.master   bus
);

  // One phase counter is shared by PLL_RESET, FILTER and HOLD, so size it for the largest.
  localparam int unsigned MaxA     = (PLL_RST_CYCLES > LOCK_FILTER) ? PLL_RST_CYCLES
                                                                    : LOCK_FILTER;
  localparam int unsigned PhaseMax = (MaxA > RST_HOLD) ? MaxA : RST_HOLD;
  localparam int unsigned PhW      = $clog2(PhaseMax + 1);
  localparam int unsigned TmoW     = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StPllReset,
    StWaitLock,
    StFilter,
    StHold,
    StRun
  } state_e;

  state_e                 state_q, state_d;
  logic [PhW-1:0]         phase_q, phase_d;
  logic [TmoW-1:0]        tmo_q, tmo_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       loss_q, loss_d;
  logic [CNT_W-1:0]       tcnt_q, tcnt_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   rst_q, rst_d;
  logic                   ready_q, ready_d;

  logic locked_s;
  logic timeout;

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign timeout  = (tmo_q == TmoW'(LOCK_TIMEOUT - 1));

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    tmo_d   = tmo_q;
    loss_d  = loss_q;
    tcnt_d  = tcnt_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.i_locked};

    case (state_q)
      StPllReset: begin
        if (phase_q == PhW'(PLL_RST_CYCLES - 1)) begin
          state_d = StWaitLock;
          phase_d = '0;
          tmo_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StWaitLock: begin
        tmo_d = tmo_q + 1'b1;
        if (timeout) begin
          state_d = StPllReset;
          phase_d = '0;
          tcnt_d  = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
        end else if (locked_s) begin
          state_d = StFilter;
          phase_d = '0;
        end
      end
      StFilter: begin
        // Timeout is checked first so it wins over a filter completing on the same edge.
        tmo_d = tmo_q + 1'b1;
        if (timeout) begin
          state_d = StPllReset;
          phase_d = '0;
          tcnt_d  = (&tcnt_q) ? tcnt_q : tcnt_q + 1'b1;
        end else if (!locked_s) begin
          state_d = StWaitLock;
        end else if (phase_q == PhW'(LOCK_FILTER - 1)) begin
          state_d = StHold;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StHold: begin
        if (!locked_s) begin
          state_d = StPllReset;
          phase_d = '0;
          loss_d  = (&loss_q) ? loss_q : loss_q + 1'b1;
        end else if (phase_q == PhW'(RST_HOLD - 1)) begin
          state_d = StRun;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d = StPllReset;
          phase_d = '0;
          loss_d  = (&loss_q) ? loss_q : loss_q + 1'b1;
        end
      end
      default: begin
        state_d = StPllReset;
        phase_d = '0;
      end
    endcase

    // Outputs come from the next state so they switch on the same edge as the FSM.
    pll_rst_d = (state_d == StPllReset);
    rst_d     = (state_d != StRun);
    ready_d   = (state_d == StRun);
  end

  // All state, with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StPllReset;
      phase_q   <= '0;
      tmo_q     <= '0;
      sync_q    <= '0;
      loss_q    <= '0;
      tcnt_q    <= '0;
      pll_rst_q <= 1'b1;
      rst_q     <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      tmo_q     <= tmo_d;
      sync_q    <= sync_d;
      loss_q    <= loss_d;
      tcnt_q    <= tcnt_d;
      pll_rst_q <= pll_rst_d;
      rst_q     <= rst_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.o_pll_rst       = pll_rst_q;
  assign bus.o_rst           = rst_q;
  assign bus.o_ready         = ready_q;
  assign bus.o_loss_count    = loss_q;
  assign bus.o_timeout_count = tcnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor with small parameters: table of per-edge expectations for
// bring-up, no-lock, filter glitch, timeout priority and lock loss, then hand sequences
// for counter saturation and reset during HOLD.
module tb_pll_lock_supervisor;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  pll_lock_supervisor_if #(.CNT_W(8)) bus ();

  pll_lock_supervisor #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_FILTER   (8),
    .RST_HOLD      (3),
    .LOCK_TIMEOUT  (40),
    .CNT_W         (8)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record: scenario, lock stimulus, the edge to stop at and the outputs expected then.
  // i_locked is 'base' except on sampling edges glo..ghi, where it is inverted.
  typedef struct {
    int   scen;
    logic base;
    int   glo;
    int   ghi;
    int   edge_n;
    logic pll;
    logic rst;
    logic rdy;
    int   loss;
    int   tmo;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];
  vec_t sb_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic lk);
    bus.i_locked = lk;
    rst_n = 1'b0;
    tick();
    cyc = 0;
    rst_n = 1'b1;
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input logic v, input int bound, input string name);
    int n;
    n = 0;
    while (bus.o_ready !== v && n < bound) begin
      tick();
      n++;
    end
    if (bus.o_ready !== v) check_int(name, 32'(bus.o_ready), 32'(v));
  endtask

  initial begin
    vec_t e;
    int   cur;
    int   n;
    string nm;

    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    rst_n = 1'b0;
    bus.i_locked = 1'b0;

    // Scenario 0: clean bring-up, lock constant high.
    tbl[0]  = '{0, 1'b1, -1, -1,   0, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[1]  = '{0, 1'b1, -1, -1,   3, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[2]  = '{0, 1'b1, -1, -1,   4, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[3]  = '{0, 1'b1, -1, -1,  15, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[4]  = '{0, 1'b1, -1, -1,  16, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[5]  = '{0, 1'b1, -1, -1,  30, 1'b0, 1'b0, 1'b1, 0, 0};
    // Scenario 1: never locks; 4-cycle PLL reset every 44 cycles, timeout count climbs.
    tbl[6]  = '{1, 1'b0, -1, -1,  43, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[7]  = '{1, 1'b0, -1, -1,  44, 1'b1, 1'b1, 1'b0, 0, 1};
    tbl[8]  = '{1, 1'b0, -1, -1,  47, 1'b1, 1'b1, 1'b0, 0, 1};
    tbl[9]  = '{1, 1'b0, -1, -1,  48, 1'b0, 1'b1, 1'b0, 0, 1};
    tbl[10] = '{1, 1'b0, -1, -1,  88, 1'b1, 1'b1, 1'b0, 0, 2};
    tbl[11] = '{1, 1'b0, -1, -1, 132, 1'b1, 1'b1, 1'b0, 0, 3};
    // Scenario 2: lock low on sampling edges 7-8 while filtering. FSM sees it at edges
    // 9-10, refilters from edge 11, HOLD at 19, RUN at 22.
    tbl[12] = '{2, 1'b1,  7,  8,   9, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[13] = '{2, 1'b1,  7,  8,  16, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[14] = '{2, 1'b1,  7,  8,  21, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[15] = '{2, 1'b1,  7,  8,  22, 1'b0, 1'b0, 1'b1, 0, 0};
    // Scenario 3: lock arrives so FILTER would finish at edge 44, the same edge the
    // timeout fires; timeout wins, then a clean relock reaches RUN at edge 60.
    tbl[16] = '{3, 1'b0, 34, 100000, 43, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[17] = '{3, 1'b0, 34, 100000, 44, 1'b1, 1'b1, 1'b0, 0, 1};
    tbl[18] = '{3, 1'b0, 34, 100000, 59, 1'b0, 1'b1, 1'b0, 0, 1};
    tbl[19] = '{3, 1'b0, 34, 100000, 60, 1'b0, 0, 1'b1, 0, 1};
    // Scenario 4: one-cycle lock drop in RUN sampled at edge 20; o_rst back at 22,
    // PLL reset 22..25, relock to RUN at 38.
    tbl[20] = '{4, 1'b1, 20, 20,  21, 1'b0, 1'b0, 1'b1, 0, 0};
    tbl[21] = '{4, 1'b1, 20, 20,  22, 1'b1, 1'b1, 1'b0, 1, 0};
    tbl[22] = '{4, 1'b1, 20, 20,  25, 1'b1, 1'b1, 1'b0, 1, 0};
    tbl[23] = '{4, 1'b1, 20, 20,  26, 1'b0, 1'b1, 1'b0, 1, 0};
    tbl[24] = '{4, 1'b1, 20, 20,  37, 1'b0, 1'b1, 1'b0, 1, 0};
    tbl[25] = '{4, 1'b1, 20, 20,  38, 1'b0, 1'b0, 1'b1, 1, 0};

    cur = -1;
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].scen != cur) begin
        cur = tbl[i].scen;
        do_reset(tbl[i].base);
      end
      while (cyc < tbl[i].edge_n) begin
        if ((cyc + 1) >= tbl[i].glo && (cyc + 1) <= tbl[i].ghi) bus.i_locked = ~tbl[i].base;
        else bus.i_locked = tbl[i].base;
        tick();
      end
      sb_q.push_back(tbl[i]);
      e = sb_q.pop_front();
      nm = $sformatf("s%0d_e%0d", e.scen, e.edge_n);
      check_int({nm, "_pll_rst"}, 32'(bus.o_pll_rst), 32'(e.pll));
      check_int({nm, "_rst"}, 32'(bus.o_rst), 32'(e.rst));
      check_int({nm, "_ready"}, 32'(bus.o_ready), 32'(e.rdy));
      check_int({nm, "_loss"}, 32'(bus.o_loss_count), e.loss);
      check_int({nm, "_tmo"}, 32'(bus.o_timeout_count), e.tmo);
    end

    // Saturation: 300 lock losses from RUN; loss count must stop at 255.
    do_reset(1'b1);
    for (int i = 0; i < 300; i++) begin
      wait_ready(1'b1, 200, "sat_wait_run");
      bus.i_locked = 1'b0;
      tick();
      bus.i_locked = 1'b1;
      wait_ready(1'b0, 10, "sat_wait_drop");
      if (i == 0) check_int("sat_loss_1", 32'(bus.o_loss_count), 1);
      if (i == 253) check_int("sat_loss_254", 32'(bus.o_loss_count), 254);
    end
    check_int("sat_loss_300", 32'(bus.o_loss_count), 255);
    check_int("sat_tmo", 32'(bus.o_timeout_count), 0);

    // Accumulate two timeouts, then relock and reset mid-HOLD.
    bus.i_locked = 1'b0;
    n = 0;
    while (bus.o_timeout_count != 8'd2 && n < 300) begin
      tick();
      n++;
    end
    check_int("tmo_reach_2", 32'(bus.o_timeout_count), 2);
    // Timeout edge T just passed: WAIT at T+4, FILTER at T+5, HOLD from T+13 to T+15.
    bus.i_locked = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check_int("hold_rst", 32'(bus.o_rst), 1);
    check_int("hold_pll_rst", 32'(bus.o_pll_rst), 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_int("midrst_pll_rst", 32'(bus.o_pll_rst), 1);
    check_int("midrst_rst", 32'(bus.o_rst), 1);
    check_int("midrst_ready", 32'(bus.o_ready), 0);
    check_int("midrst_loss", 32'(bus.o_loss_count), 0);
    check_int("midrst_tmo", 32'(bus.o_timeout_count), 0);
    // Phase counter restarted: PLL reset still high 3 edges later, low on the 4th.
    for (int i = 0; i < 3; i++) tick();
    check_int("midrst_pll_e3", 32'(bus.o_pll_rst), 1);
    tick();
    check_int("midrst_pll_e4", 32'(bus.o_pll_rst), 0);
    for (int i = 0; i < 12; i++) tick();
    check_int("midrst_run_ready", 32'(bus.o_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
